// File: rtl/gpio_input_router.sv
// Pad-input router: synchronises each GPIO pad, detects edges into sticky per-pin status, and routes level/IRQ to the owning design.
// Optional debounce filter is enabled by defining GPIO_IN_DEBOUNCE_EN.
module gpio_input_router #(
  parameter int unsigned NUM_PINS    = 38,
  parameter int unsigned NUM_DESIGNS = 13,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned DB_CYCLES   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PINS-1:0]             io_in,
  input  logic [NUM_PINS*SEL_W-1:0]       pin_sel,
  input  logic [NUM_PINS-1:0]             rise_en,
  input  logic [NUM_PINS-1:0]             fall_en,
  input  logic [NUM_PINS-1:0]             irq_clr,
  output logic [NUM_DESIGNS*NUM_PINS-1:0] design_io_in,
  output logic [NUM_PINS-1:0]             pin_sync,
  output logic [NUM_PINS-1:0]             irq_status,
  output logic [NUM_DESIGNS-1:0]          design_irq
);

  localparam int unsigned WARM_W    = 2;
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(3);

  // Owner codes must be able to name every design slot; a zero debounce window is meaningless.
  if (((32'd1 << SEL_W) < NUM_DESIGNS) || (DB_CYCLES == 0)) begin : g_param_check
    $error("gpio_input_router: invalid SEL_W/NUM_DESIGNS/DB_CYCLES combination");
  end

  logic [NUM_PINS-1:0] s1_q, s2_q;
  logic [NUM_PINS-1:0] prev_q;
  logic [NUM_PINS-1:0] status_q, status_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic [NUM_PINS-1:0] filt;
  logic [NUM_PINS-1:0] rise_ev, fall_ev;
  logic                armed;

  // Warm-up counter: edges are ignored until the sync/filter pipeline holds real pad data.
  always_comb begin
    warm_d = warm_q;
    if (warm_q != WARM_DONE) begin
      warm_d = WARM_W'(warm_q + WARM_W'(1));
    end
  end

  assign armed = (warm_q == WARM_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
      status_q <= '0;
      warm_q   <= '0;
    end else begin
      s1_q     <= io_in;
      s2_q     <= s1_q;
      prev_q   <= filt;
      status_q <= status_d;
      warm_q   <= warm_d;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic [NUM_PINS-1:0] filt_q, filt_d;
  logic [CNT_W-1:0]    cnt_q [NUM_PINS];
  logic [CNT_W-1:0]    cnt_d [NUM_PINS];

  // A new level is accepted only after it has differed from the filter for DB_CYCLES clocks.
  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < NUM_PINS; i++) begin
      cnt_d[i] = '0;
      if (!armed) begin
        filt_d[i] = s2_q[i];
      end else if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
          filt_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = CNT_W'(cnt_q[i] + CNT_W'(1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
      cnt_q  <= '{default: '0};
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = s2_q;
`endif

  // Sticky status: a new event wins over a simultaneous clear.
  always_comb begin
    rise_ev  = filt & ~prev_q & rise_en & {NUM_PINS{armed}};
    fall_ev  = ~filt & prev_q & fall_en & {NUM_PINS{armed}};
    status_d = rise_ev | fall_ev | (status_q & ~irq_clr);
  end

  assign pin_sync   = filt;
  assign irq_status = status_q;

  logic [SEL_W-1:0] owner [NUM_PINS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_PINS; i++) begin
      owner[i] = pin_sel[i*SEL_W +: SEL_W];
    end
  end

  // Routing and per-design IRQ follow pin_sel combinationally; unowned codes reach no design.
  always_comb begin
    design_io_in = '0;
    design_irq   = '0;
    for (int unsigned i = 0; i < NUM_PINS; i++) begin
      for (int unsigned d = 0; d < NUM_DESIGNS; d++) begin
        if (owner[i] == SEL_W'(d)) begin
          design_io_in[d*NUM_PINS + i] = pin_sync[i];
          design_irq[d]                = design_irq[d] | irq_status[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio_input_router.sv
// Scoreboard bench for gpio_input_router: stimulus queues timed expectations, a negedge monitor checks them.
// Defining GPIO_IN_DEBOUNCE_EN switches the stimulus to the debounce scenarios.
module tb_gpio_input_router;
  localparam int NP = 38;
  localparam int ND = 13;
  localparam int SW = 4;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     io_in;
  logic [NP*SW-1:0]  pin_sel;
  logic [NP-1:0]     rise_en;
  logic [NP-1:0]     fall_en;
  logic [NP-1:0]     irq_clr;
  logic [ND*NP-1:0]  design_io_in;
  logic [NP-1:0]     pin_sync;
  logic [NP-1:0]     irq_status;
  logic [ND-1:0]     design_irq;

  gpio_input_router #(
    .NUM_PINS(NP), .NUM_DESIGNS(ND), .SEL_W(SW), .DB_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .io_in(io_in), .pin_sel(pin_sel),
    .rise_en(rise_en), .fall_en(fall_en), .irq_clr(irq_clr),
    .design_io_in(design_io_in), .pin_sync(pin_sync),
    .irq_status(irq_status), .design_irq(design_irq)
  );

  typedef enum int {K_SYNC, K_STAT, K_DIO, K_DIO_PIN, K_DIO_CNT, K_DIRQ, K_SYNCV, K_STATV} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    int          idx;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sample(kind_e k, int idx);
    logic [63:0] v;
    v = '0;
    case (k)
      K_SYNC:    v = 64'(pin_sync[idx]);
      K_STAT:    v = 64'(irq_status[idx]);
      K_DIO:     v = 64'(design_io_in[idx]);
      K_DIO_PIN: for (int d = 0; d < ND; d++) v[0] = v[0] | design_io_in[d*NP + idx];
      K_DIO_CNT: v = 64'($countones(design_io_in));
      K_DIRQ:    v = 64'(design_irq);
      K_SYNCV:   v = 64'(pin_sync);
      K_STATV:   v = 64'(irq_status);
      default:   v = '1;
    endcase
    return v;
  endfunction

  function automatic void push_exp(int dc, kind_e k, int idx, logic [63:0] e, string nm);
    chk_t c;
    c.cyc = cyc + dc; c.kind = k; c.idx = idx; c.exp = e; c.name = nm;
    sb.push_back(c);
  endfunction

  // Monitor: compare every queued expectation due in the current cycle.
  always @(negedge clk) begin
    logic [63:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = sample(sb[i].kind, sb[i].idx);
        n_cmp++;
        if (act !== sb[i].exp) begin
          n_bad++;
          $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s missed at cyc=%0d (due %0d)", sb[i].name, cyc, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_owner(int p, int o);
    pin_sel[p*SW +: SW] = SW'(o);
  endtask

  initial begin
    rst     = 1'b1;
    io_in   = '0;
    pin_sel = '1;
    rise_en = '0;
    fall_en = '0;
    irq_clr = '0;
    set_owner(0, 0);
`ifndef GPIO_IN_DEBOUNCE_EN
    io_in[0]   = 1'b1;
    rise_en[0] = 1'b1;
`endif
    tick(1);
    push_exp(1, K_SYNCV,   0, 64'd0, "rst_pin_sync");
    push_exp(1, K_STATV,   0, 64'd0, "rst_irq_status");
    push_exp(1, K_DIRQ,    0, 64'd0, "rst_design_irq");
    push_exp(1, K_DIO_CNT, 0, 64'd0, "rst_design_io_in");
    tick(4);
    rst = 1'b0;
`ifndef GPIO_IN_DEBOUNCE_EN
    // Pin 0 high through reset: level appears, no edge is reported.
    push_exp(1, K_SYNC, 0, 64'd0, "warm_sync0_early");
    push_exp(2, K_SYNC, 0, 64'd1, "warm_sync0");
    push_exp(2, K_DIO,  0, 64'd1, "warm_dio_d0_p0");
    push_exp(3, K_STAT, 0, 64'd0, "warm_stat0_a");
    push_exp(5, K_STAT, 0, 64'd0, "warm_stat0_b");
    push_exp(5, K_DIRQ, 0, 64'd0, "warm_dirq");
    tick(6);

    // Pin 5 owned by design 3, rising edge.
    set_owner(5, 3);
    rise_en[5] = 1'b1;
    tick(1);
    io_in[5] = 1'b1;
    push_exp(1, K_SYNC,    5,        64'd0, "p5_sync_early");
    push_exp(2, K_SYNC,    5,        64'd1, "p5_sync");
    push_exp(2, K_DIO,     3*NP + 5, 64'd1, "p5_dio_d3");
    push_exp(2, K_DIO_PIN, 5,        64'd1, "p5_dio_any");
    push_exp(2, K_DIO_CNT, 0,        64'd2, "p5_dio_count");
    push_exp(2, K_STAT,    5,        64'd0, "p5_stat_early");
    push_exp(2, K_DIRQ,    0,        64'd0, "p5_dirq_early");
    push_exp(3, K_STAT,    5,        64'd1, "p5_stat");
    push_exp(3, K_DIRQ,    0,        64'h8, "p5_dirq");
    tick(4);

    // Clear alone.
    irq_clr[5] = 1'b1;
    push_exp(0, K_STAT, 5, 64'd1, "clr_stat_before");
    push_exp(1, K_STAT, 5, 64'd0, "clr_stat_after");
    push_exp(1, K_DIRQ, 0, 64'd0, "clr_dirq_after");
    tick(1);
    irq_clr = '0;

    // Status set, then clear coincident with a fresh rising event.
    io_in[5] = 1'b0;
    tick(3);
    io_in[5] = 1'b1;
    tick(3);
    io_in[5] = 1'b0;
    tick(3);
    io_in[5] = 1'b1;
    tick(2);
    push_exp(0, K_STAT, 5, 64'd1, "setclr_stat_before");
    irq_clr[5] = 1'b1;
    push_exp(1, K_STAT, 5, 64'd1, "setclr_stat_kept");
    tick(1);
    irq_clr = '0;
    tick(1);
    irq_clr[5] = 1'b1;
    push_exp(1, K_STAT, 5, 64'd0, "clr2_stat");
    tick(1);
    irq_clr = '0;

    // Pin 7 with an unowned code.
    set_owner(7, 14);
    rise_en[7] = 1'b1;
    tick(1);
    io_in[7] = 1'b1;
    push_exp(2, K_SYNC,    7, 64'd1, "p7_sync");
    push_exp(2, K_DIO_PIN, 7, 64'd0, "p7_dio_none");
    push_exp(2, K_DIO_CNT, 0, 64'd2, "p7_dio_count");
    push_exp(3, K_STAT,    7, 64'd1, "p7_stat");
    push_exp(3, K_DIRQ,    0, 64'd0, "p7_dirq_none");
    tick(4);

    // Retarget pin 7 to design 2 mid-operation.
    set_owner(7, 2);
    push_exp(0, K_DIRQ, 0,        64'h4, "retarget_dirq");
    push_exp(0, K_DIO,  2*NP + 7, 64'd1, "retarget_dio");
    push_exp(0, K_STAT, 7,        64'd1, "retarget_stat");
    push_exp(1, K_STAT, 7,        64'd1, "retarget_stat_next");
    tick(2);

    // Pin 9 falling edge, first with fall_en off.
    set_owner(9, 4);
    io_in[9] = 1'b1;
    tick(4);
    io_in[9] = 1'b0;
    push_exp(2, K_SYNC, 9, 64'd0, "p9_sync_low");
    push_exp(3, K_STAT, 9, 64'd0, "p9_nofall_a");
    push_exp(4, K_STAT, 9, 64'd0, "p9_nofall_b");
    tick(5);
    io_in[9] = 1'b1;
    tick(4);
    fall_en[9] = 1'b1;
    io_in[9]   = 1'b0;
    push_exp(2, K_STAT, 9, 64'd0,  "p9_fall_early");
    push_exp(3, K_STAT, 9, 64'd1,  "p9_fall");
    push_exp(3, K_DIRQ, 0, 64'h14, "p9_dirq");
    tick(5);

    // Reset mid-operation with pins 0, 5, 7 high: warm-up restarts, no edges.
    rst = 1'b1;
    push_exp(1, K_SYNCV,   0, 64'd0, "mrst_sync");
    push_exp(1, K_STATV,   0, 64'd0, "mrst_stat");
    push_exp(1, K_DIRQ,    0, 64'd0, "mrst_dirq");
    push_exp(1, K_DIO_CNT, 0, 64'd0, "mrst_dio");
    tick(1);
    rst = 1'b0;
    push_exp(1, K_SYNCV,   0, 64'd0,    "mrst_sync_early");
    push_exp(2, K_SYNCV,   0, 64'h0A1,  "mrst_sync_back");
    push_exp(2, K_DIO_CNT, 0, 64'd3,    "mrst_dio_back");
    push_exp(3, K_STATV,   0, 64'd0,    "mrst_stat_a");
    push_exp(6, K_STATV,   0, 64'd0,    "mrst_stat_b");
    push_exp(6, K_DIRQ,    0, 64'd0,    "mrst_dirq_b");
    tick(8);
`else
    tick(5);
    // Debounce: short glitch rejected, long pulse accepted after 2 + DB_CYCLES clocks.
    set_owner(3, 1);
    io_in[3] = 1'b1;
    push_exp(3,  K_SYNC, 3, 64'd0, "glitch_a");
    push_exp(7,  K_SYNC, 3, 64'd0, "glitch_b");
    push_exp(12, K_SYNC, 3, 64'd0, "glitch_c");
    push_exp(22, K_SYNC, 3, 64'd0, "glitch_d");
    tick(5);
    io_in[3] = 1'b0;
    tick(25);
    io_in[3] = 1'b1;
    push_exp(2,  K_SYNC, 3,        64'd0, "hold_early");
    push_exp(17, K_SYNC, 3,        64'd0, "hold_17");
    push_exp(18, K_SYNC, 3,        64'd1, "hold_18");
    push_exp(18, K_DIO,  1*NP + 3, 64'd1, "hold_dio_d1");
    push_exp(19, K_STATV, 0,       64'd0, "hold_no_irq");
    tick(20);
`endif

    // Drain remaining expectations with a bounded wait.
    for (int k = 0; k < 50 && sb.size() != 0; k++) tick(1);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain %0d expectations left required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
